udp_frame_buf: RTL and testbench

- Ping-pong sample buffer directly upstream of the UDP sender.
- Acquisition logic fills one bank with 32-bit words. On each measurement sync (msync_n falling edge) the banks swap: the completed bank is frozen and presented to the sender's read port, and filling continues in the other bank.
- Supplies the sender's rd_addr/rd_data interface and its msync_n strobe. The sender reads the frozen bank while the next frame accumulates.

---
 rtl/udp_buf_pkg.sv | 10 +
 rtl/udp_frame_ram.sv | 21 ++
 rtl/udp_frame_buf.sv | 154 +++++++++++++++
 tb/tb_udp_frame_buf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_buf_pkg.sv
// Shared constants for the UDP ping-pong frame buffer: default geometry,
// drop-counter width and FSM state encoding.
package udp_buf_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int DROP_W     = 16;

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;
endpackage

// File: rtl/udp_frame_ram.sv
// Simple dual-port RAM holding both ping-pong banks; address is {bank, addr}.
// Registered read, no reset on the array so it maps onto one block RAM.
module udp_frame_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W:0]   raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/udp_frame_buf.sv
// Ping-pong sample buffer feeding the UDP sender; banks swap on each msync.
// Optional macro UDP_FRAME_BUF_SEQ_EN adds a frame sequence header at address 0.
module udp_frame_buf
    import udp_buf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_msync_n,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_vld,
    input  logic              i_rd_busy,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_msync_n,
    output logic [ADDR_W:0]   o_frame_len,
    output logic              o_frame_ovf,
    output logic [DROP_W-1:0] o_drop_cnt
);
    localparam int FL_W = ADDR_W + 1;
`ifdef UDP_FRAME_BUF_SEQ_EN
    localparam logic [ADDR_W:0] BASE  = FL_W'(1);
    localparam logic [ADDR_W:0] CAP   = FL_W'(2**ADDR_W - 1);
    localparam int              PAD_W = DATA_W - 16 - FL_W;
`else
    localparam logic [ADDR_W:0] BASE  = FL_W'(0);
    localparam logic [ADDR_W:0] CAP   = FL_W'(2**ADDR_W);
`endif

    logic              msync_s1, msync_s2, msync_s3, sync_evt;
    logic              wr_bank, rd_bank;
    logic [ADDR_W:0]   wr_cnt;
    logic              ovf;
    logic [0:0]        state;
    logic              accept, drop_word, swap;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] ram_q;
    logic              rd_zero_p1;

    assign accept    = i_wr_vld && (wr_cnt < CAP);
    assign drop_word = i_wr_vld && !(wr_cnt < CAP);
    assign swap      = !i_rd_busy && ((state == S_RUN && sync_evt) || state == S_PEND);
    assign wr_addr   = BASE[ADDR_W-1:0] + wr_cnt[ADDR_W-1:0];

    // Stage: pin synchronizer and falling-edge detect (pin edge to sync_evt = 3 clk)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msync_s1 <= 1'b1;
            msync_s2 <= 1'b1;
            msync_s3 <= 1'b1;
            sync_evt <= 1'b0;
        end else begin
            msync_s1 <= i_msync_n;
            msync_s2 <= msync_s1;
            msync_s3 <= msync_s2;
            sync_evt <= msync_s3 & ~msync_s2;
        end
    end

    // Stage: fill counter, bank swap and frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            wr_cnt      <= '0;
            ovf         <= 1'b0;
            state       <= S_RUN;
            o_frame_len <= '0;
            o_frame_ovf <= 1'b0;
            o_drop_cnt  <= '0;
            o_msync_n   <= 1'b1;
        end else begin
            o_msync_n <= ~swap;
            if (swap) begin
                rd_bank     <= wr_bank;
                wr_bank     <= ~wr_bank;
                o_frame_len <= wr_cnt + FL_W'(accept);
                o_frame_ovf <= ovf | drop_word;
                wr_cnt      <= '0;
                ovf         <= 1'b0;
            end else begin
                if (accept)
                    wr_cnt <= wr_cnt + FL_W'(1);
                if (drop_word)
                    ovf <= 1'b1;
            end

            case (state)
                S_RUN:   if (sync_evt && i_rd_busy) state <= S_PEND;
                S_PEND:  if (!i_rd_busy) state <= S_RUN;
                default: state <= S_RUN;
            endcase

            // Only one swap can be queued; later syncs are counted as lost.
            if (state == S_PEND && sync_evt && o_drop_cnt != {DROP_W{1'b1}})
                o_drop_cnt <= o_drop_cnt + DROP_W'(1);
        end
    end

    udp_frame_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wr_bank, wr_addr}),
        .wdata (i_wr_data),
        .raddr ({rd_bank, i_rd_addr}),
        .rdata (ram_q)
    );

    // Stage: read qualifier, aligned with the registered RAM output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_zero_p1 <= 1'b1;
        else
            rd_zero_p1 <= ({1'b0, i_rd_addr} >= (BASE + o_frame_len));
    end

`ifdef UDP_FRAME_BUF_SEQ_EN
    logic [15:0]       seq_cnt, frozen_seq;
    logic              hdr_sel_p1;
    logic [DATA_W-1:0] hdr_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt    <= '0;
            frozen_seq <= '0;
            hdr_sel_p1 <= 1'b0;
        end else begin
            if (swap) begin
                frozen_seq <= seq_cnt;
                seq_cnt    <= seq_cnt + 16'd1;
            end
            hdr_sel_p1 <= (i_rd_addr == '0);
        end
    end

    always_ff @(posedge clk)
        hdr_p1 <= {frozen_seq, {PAD_W{1'b0}}, o_frame_len};

    always_comb begin
        o_rd_data = ram_q;
        if (hdr_sel_p1)
            o_rd_data = hdr_p1;
        else if (rd_zero_p1)
            o_rd_data = '0;
    end
`else
    assign o_rd_data = rd_zero_p1 ? '0 : ram_q;
`endif
endmodule

// File: tb/tb_udp_frame_buf.sv
// Directed self-checking bench for udp_frame_buf (default build, and the
// UDP_FRAME_BUF_SEQ_EN build when that macro is defined).
module tb_udp_frame_buf;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
`ifdef UDP_FRAME_BUF_SEQ_EN
    localparam int BASE = 1;
    localparam int CAP  = 1023;
`else
    localparam int BASE = 0;
    localparam int CAP  = 1024;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_msync_n;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_wr_vld;
    logic              i_rd_busy;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_msync_n;
    logic [ADDR_W:0]   o_frame_len;
    logic              o_frame_ovf;
    logic [15:0]       o_drop_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    udp_frame_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_msync_n   (i_msync_n),
        .i_wr_data   (i_wr_data),
        .i_wr_vld    (i_wr_vld),
        .i_rd_busy   (i_rd_busy),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_msync_n   (o_msync_n),
        .o_frame_len (o_frame_len),
        .o_frame_ovf (o_frame_ovf),
        .o_drop_cnt  (o_drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            i_wr_vld  = 1'b1;
            i_wr_data = DATA_W'(first + i);
            tick();
        end
        i_wr_vld = 1'b0;
    endtask

    task automatic read_word(input int addr, output logic [DATA_W-1:0] d);
        i_rd_addr = ADDR_W'(addr);
        tick();
        d = o_rd_data;
    endtask

    task automatic pulse_pin(output int strobes);
        strobes   = 0;
        i_msync_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 2) i_msync_n = 1'b1;
            if (o_msync_n === 1'b0) strobes++;
        end
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d;
        rst_n = 1'b0; i_msync_n = 1'b1; i_wr_data = '0; i_wr_vld = 1'b0;
        i_rd_busy = 1'b0; i_rd_addr = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tests++; if (o_msync_n !== 1'b1) begin failed++; $display("FAIL reset_msync: got %0b expected 1", o_msync_n); end
        tests++; if (o_frame_len !== '0) begin failed++; $display("FAIL reset_len: got %0d expected 0", o_frame_len); end
        tests++; if (o_frame_ovf !== 1'b0) begin failed++; $display("FAIL reset_ovf: got %0b expected 0", o_frame_ovf); end
        tests++; if (o_drop_cnt !== 16'd0) begin failed++; $display("FAIL reset_drop: got %0d expected 0", o_drop_cnt); end
        read_word(5, d);
        tests++; if (d !== '0) begin failed++; $display("FAIL reset_rd_data: got %0h expected 0", d); end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] d;
        write_words(100, 0);
        i_msync_n = 1'b0;
        tick(); tick(); tick();
        tests++; if (o_msync_n !== 1'b1) begin failed++; $display("FAIL basic_strobe_early: got %0b expected 1", o_msync_n); end
        tick();
        tests++; if (o_msync_n !== 1'b0) begin failed++; $display("FAIL basic_strobe_at4: got %0b expected 0", o_msync_n); end
        tick();
        tests++; if (o_msync_n !== 1'b1) begin failed++; $display("FAIL basic_strobe_width: got %0b expected 1", o_msync_n); end
        i_msync_n = 1'b1;
        tick(); tick(); tick();
        tests++; if (o_frame_len !== 11'd100) begin failed++; $display("FAIL basic_len: got %0d expected 100", o_frame_len); end
        tests++; if (o_frame_ovf !== 1'b0) begin failed++; $display("FAIL basic_ovf: got %0b expected 0", o_frame_ovf); end
        read_word(5, d);
        tests++; if (d !== DATA_W'(5 - BASE)) begin failed++; $display("FAIL basic_addr5: got %0d expected %0d", d, 5 - BASE); end
        read_word(BASE + 99, d);
        tests++; if (d !== 32'd99) begin failed++; $display("FAIL basic_last: got %0d expected 99", d); end
        read_word(BASE + 100, d);
        tests++; if (d !== '0) begin failed++; $display("FAIL basic_past_len: got %0d expected 0", d); end
        read_word(150, d);
        tests++; if (d !== '0) begin failed++; $display("FAIL basic_addr150: got %0d expected 0", d); end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] d;
        int s;
        write_words(1030, 1000);
        pulse_pin(s);
        tests++; if (s != 1) begin failed++; $display("FAIL ovf_strobes: got %0d expected 1", s); end
        tests++; if (o_frame_len !== 11'(CAP)) begin failed++; $display("FAIL ovf_len: got %0d expected %0d", o_frame_len, CAP); end
        tests++; if (o_frame_ovf !== 1'b1) begin failed++; $display("FAIL ovf_flag: got %0b expected 1", o_frame_ovf); end
        read_word(BASE + CAP - 1, d);
        tests++; if (d !== DATA_W'(1000 + CAP - 1)) begin failed++; $display("FAIL ovf_last_word: got %0d expected %0d", d, 1000 + CAP - 1); end
        write_words(10, 2000);
        pulse_pin(s);
        tests++; if (o_frame_len !== 11'd10) begin failed++; $display("FAIL ovf_next_len: got %0d expected 10", o_frame_len); end
        tests++; if (o_frame_ovf !== 1'b0) begin failed++; $display("FAIL ovf_next_flag: got %0b expected 0", o_frame_ovf); end
    endtask

    task automatic test_pending();
        logic [DATA_W-1:0] d;
        int s;
        i_rd_busy = 1'b1;
        write_words(10, 300);
        pulse_pin(s);
        tests++; if (s != 0) begin failed++; $display("FAIL pend_no_strobe: got %0d expected 0", s); end
        write_words(20, 310);
        tests++; if (o_frame_len !== 11'd10) begin failed++; $display("FAIL pend_len_held: got %0d expected 10", o_frame_len); end
        i_rd_busy = 1'b0;
        tick();
        tests++; if (o_msync_n !== 1'b0) begin failed++; $display("FAIL pend_release_strobe: got %0b expected 0", o_msync_n); end
        tests++; if (o_frame_len !== 11'd30) begin failed++; $display("FAIL pend_len: got %0d expected 30", o_frame_len); end
        tests++; if (o_drop_cnt !== 16'd0) begin failed++; $display("FAIL pend_drop: got %0d expected 0", o_drop_cnt); end
        read_word(BASE + 29, d);
        tests++; if (d !== 32'd329) begin failed++; $display("FAIL pend_last_word: got %0d expected 329", d); end
    endtask

    task automatic test_drops();
        int s;
        int total = 0;
        i_rd_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse_pin(s);
            total += s;
        end
        tests++; if (total != 0) begin failed++; $display("FAIL drops_no_strobe: got %0d expected 0", total); end
        tests++; if (o_drop_cnt !== 16'd2) begin failed++; $display("FAIL drops_cnt: got %0d expected 2", o_drop_cnt); end
        i_rd_busy = 1'b0;
        total = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_msync_n === 1'b0) total++;
        end
        tests++; if (total != 1) begin failed++; $display("FAIL drops_one_strobe: got %0d expected 1", total); end
        tests++; if (o_frame_len !== 11'd0) begin failed++; $display("FAIL drops_len: got %0d expected 0", o_frame_len); end
    endtask

    task automatic test_same_cycle();
        logic [DATA_W-1:0] d;
        int s;
        write_words(5, 500);
        i_msync_n = 1'b0;
        tick(); tick(); tick();
        i_wr_vld  = 1'b1;
        i_wr_data = 32'hABCD;
        tick();
        i_wr_vld  = 1'b0;
        tests++; if (o_msync_n !== 1'b0) begin failed++; $display("FAIL same_strobe: got %0b expected 0", o_msync_n); end
        tests++; if (o_frame_len !== 11'd6) begin failed++; $display("FAIL same_len: got %0d expected 6", o_frame_len); end
        i_msync_n = 1'b1;
        tick(); tick(); tick(); tick();
        read_word(BASE + 5, d);
        tests++; if (d !== 32'hABCD) begin failed++; $display("FAIL same_last_word: got %0h expected abcd", d); end
        read_word(BASE + 4, d);
        tests++; if (d !== 32'd504) begin failed++; $display("FAIL same_prev_word: got %0d expected 504", d); end
        write_words(3, 700);
        pulse_pin(s);
        tests++; if (o_frame_len !== 11'd3) begin failed++; $display("FAIL same_new_bank_len: got %0d expected 3", o_frame_len); end
        read_word(BASE, d);
        tests++; if (d !== 32'd700) begin failed++; $display("FAIL same_new_bank_first: got %0d expected 700", d); end
    endtask

    task automatic test_reset_midframe();
        logic [DATA_W-1:0] d;
        int s;
        write_words(7, 900);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if (o_frame_len !== 11'd0) begin failed++; $display("FAIL rst_mid_len: got %0d expected 0", o_frame_len); end
        tests++; if (o_drop_cnt !== 16'd0) begin failed++; $display("FAIL rst_mid_drop: got %0d expected 0", o_drop_cnt); end
        write_words(4, 950);
        pulse_pin(s);
        tests++; if (s != 1) begin failed++; $display("FAIL rst_mid_strobes: got %0d expected 1", s); end
        tests++; if (o_frame_len !== 11'd4) begin failed++; $display("FAIL rst_mid_frame_len: got %0d expected 4", o_frame_len); end
        read_word(BASE, d);
        tests++; if (d !== 32'd950) begin failed++; $display("FAIL rst_mid_first: got %0d expected 950", d); end
    endtask

`ifdef UDP_FRAME_BUF_SEQ_EN
    task automatic test_seq();
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp;
        int s;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            write_words(8, 100 * k);
            pulse_pin(s);
            exp = (DATA_W'(k) << 16) | 32'd8;
            read_word(0, d);
            tests++; if (d !== exp) begin failed++; $display("FAIL seq_header%0d: got %0h expected %0h", k, d, exp); end
            read_word(1, d);
            tests++; if (d !== DATA_W'(100 * k)) begin failed++; $display("FAIL seq_first%0d: got %0d expected %0d", k, d, 100 * k); end
            read_word(8, d);
            tests++; if (d !== DATA_W'(100 * k + 7)) begin failed++; $display("FAIL seq_last%0d: got %0d expected %0d", k, d, 100 * k + 7); end
            read_word(9, d);
            tests++; if (d !== '0) begin failed++; $display("FAIL seq_past%0d: got %0d expected 0", k, d); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_pending();
        test_drops();
        test_same_cycle();
        test_reset_midframe();
`ifdef UDP_FRAME_BUF_SEQ_EN
        test_seq();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
